fetch_unit: RTL and testbench

- Front-end stage directly upstream of dispatch. Produces the `in_fetch_insnbits` / `in_fetch_done` pair that the core currently drives from its testbench.
- Holds the PC and issues in-order word requests to an instruction memory with variable latency and a ready/valid handshake.
- Buffers returned instructions in a small queue and presents them to dispatch one per cycle, honouring the dispatch stall.
- Supports a ROB-driven redirect on mispredict (flush plus discard of in-flight responses), and halts on an HLT encoding.

---
 rtl/data_structures.sv | 21 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_structures.sv
// Shared front-end types and constants.
package data_structures;

  localparam int unsigned INSN_SIZE = 32;
  localparam int unsigned PC_SIZE   = 64;

  localparam logic [INSN_SIZE-1:0] HLT_INSN = 32'hD440_0000;
  localparam logic [INSN_SIZE-1:0] NOP_INSN = 32'hD503_201F;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // One instruction queue entry: the fetched word and the PC it came from.
  typedef struct packed {
    logic [INSN_SIZE-1:0] insn;
    logic [PC_SIZE-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue with push/pop/flush and occupancy count.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, in-order imem requests, instruction queue to dispatch.
module fetch_unit
  import data_structures::*;
#(
  parameter logic [PC_SIZE-1:0] RESET_PC        = 64'h0,
  parameter int unsigned        FIFO_DEPTH      = 4,
  parameter int unsigned        MAX_OUTSTANDING = 4
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_stall,
  input  logic                 in_rob_redirect,
  input  logic [PC_SIZE-1:0]   in_rob_redirect_pc,
  output logic                 out_imem_req_valid,
  input  logic                 in_imem_req_ready,
  output logic [PC_SIZE-1:0]   out_imem_req_addr,
  input  logic                 in_imem_resp_valid,
  input  logic [INSN_SIZE-1:0] in_imem_resp_data,
  output logic                 out_d_done,
  output logic [INSN_SIZE-1:0] out_d_insnbits,
  output logic [PC_SIZE-1:0]   out_d_pc,
  output logic                 out_halted
);

  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW  = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);
  localparam int unsigned EW  = $bits(fetch_entry_t);

  fetch_state_t       state;
  fetch_state_t       state_nx;
  logic [PC_SIZE-1:0] pc;
  logic [PC_SIZE-1:0] resp_pc;
  logic [PC_SIZE-1:0] redirect_pc;
  logic [OW-1:0]      outstanding;
  logic [OW-1:0]      discard;
  logic [FCW-1:0]     fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               req_ok;
  logic               req_fire;
  logic               resp_keep;
  fetch_entry_t       fifo_wdata;
  fetch_entry_t       fifo_rdata;

  assign redirect_pc = in_rob_redirect_pc & ~(PC_SIZE'(3));

  // Credit rule: every issued request already owns a queue slot.
  assign req_ok = (state == FETCH) && !in_rob_redirect && !fifo_full
               && (outstanding < OW'(MAX_OUTSTANDING))
               && ((SW'(outstanding) + SW'(fifo_count)) < SW'(FIFO_DEPTH));
  assign req_fire           = req_ok && in_imem_req_ready;
  assign out_imem_req_valid = req_ok && in_rst;
  assign out_imem_req_addr  = pc;

  // Responses owed to a squashed path are dropped; after HLT nothing more is queued.
  assign resp_keep  = in_imem_resp_valid && (discard == '0);
  assign fifo_push  = resp_keep && (state == FETCH) && !in_rob_redirect;
  assign fifo_wdata = '{insn: in_imem_resp_data, pc: resp_pc};

  assign out_d_done     = !fifo_empty && !in_stall && !in_rob_redirect;
  assign fifo_pop       = out_d_done;
  assign out_d_insnbits = fifo_empty ? '0 : fifo_rdata.insn;
  assign out_d_pc       = fifo_empty ? '0 : fifo_rdata.pc;
  assign out_halted     = (state == HALTED);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (in_clk),
    .rst_n (in_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (in_rob_redirect),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Fetch state register.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) state <= FETCH;
    else         state <= state_nx;
  end

  // Next state: redirect always resumes fetching; a queued HLT stops it.
  always_comb begin
    state_nx = state;
    if (in_rob_redirect) begin
      state_nx = FETCH;
    end else if (fifo_push && (in_imem_resp_data == HLT_INSN)) begin
      state_nx = HALTED;
    end
  end

  // Request PC and the PC tag for the next queued response.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      pc      <= RESET_PC;
      resp_pc <= RESET_PC;
    end else if (in_rob_redirect) begin
      pc      <= redirect_pc;
      resp_pc <= redirect_pc;
    end else begin
      if (req_fire)  pc      <= pc + PC_SIZE'(4);
      if (fifo_push) resp_pc <= resp_pc + PC_SIZE'(4);
    end
  end

  // In-flight request count and number of stale responses still to drop.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      unique case ({req_fire, in_imem_resp_valid})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
      if (in_rob_redirect) begin
        discard <= outstanding - OW'(in_imem_resp_valid);
      end else if (in_imem_resp_valid && (discard != '0)) begin
        discard <= discard - OW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a variable-latency in-order memory model.
module tb_fetch_unit;
  import data_structures::*;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MAXO   = 4;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic        in_stall = 1'b0;
  logic        in_rob_redirect = 1'b0;
  logic [63:0] in_rob_redirect_pc = '0;
  logic        out_imem_req_valid;
  logic        in_imem_req_ready = 1'b0;
  logic [63:0] out_imem_req_addr;
  logic        in_imem_resp_valid = 1'b0;
  logic [31:0] in_imem_resp_data = '0;
  logic        out_d_done;
  logic [31:0] out_d_insnbits;
  logic [63:0] out_d_pc;
  logic        out_halted;

  fetch_unit #(
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .in_clk             (in_clk),
    .in_rst             (in_rst),
    .in_stall           (in_stall),
    .in_rob_redirect    (in_rob_redirect),
    .in_rob_redirect_pc (in_rob_redirect_pc),
    .out_imem_req_valid (out_imem_req_valid),
    .in_imem_req_ready  (in_imem_req_ready),
    .out_imem_req_addr  (out_imem_req_addr),
    .in_imem_resp_valid (in_imem_resp_valid),
    .in_imem_resp_data  (in_imem_resp_data),
    .out_d_done         (out_d_done),
    .out_d_insnbits     (out_d_insnbits),
    .out_d_pc           (out_d_pc),
    .out_halted         (out_halted)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } req_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  req_t        mq[$];
  logic [63:0] exp_q[$];
  int          lat = 1;
  bit          rand_ready = 1'b0;
  logic [63:0] hlt_addr = '1;
  int          fires = 0;
  int          first_fire = -1;
  int          first_done = -1;
  logic [63:0] first_addr = '0;
  int          delivered = 0;
  logic [63:0] mon_e;

  always @(posedge in_clk) cyc <= cyc + 1;

  function automatic logic [31:0] insn_at(input logic [63:0] a);
    if (a == hlt_addr) return HLT_INSN;
    return a[31:0] ^ 32'h9100_13FF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge in_clk);
    #1;
  endtask

  task automatic load_stream(input logic [63:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 64'(4 * i));
  endtask

  // Memory: responses in request order after 'lat' cycles; ready optionally random.
  initial forever begin
    @(negedge in_clk);
    if (!in_rst) begin
      mq.delete();
      in_imem_resp_valid = 1'b0;
      in_imem_resp_data  = '0;
      in_imem_req_ready  = 1'b0;
    end else begin
      in_imem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        in_imem_resp_valid = 1'b1;
        in_imem_resp_data  = insn_at(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        in_imem_resp_valid = 1'b0;
        in_imem_resp_data  = '0;
      end
      #3;
      if (out_imem_req_valid && in_imem_req_ready) begin
        mq.push_back('{addr: out_imem_req_addr, due: cyc + 1 + lat});
        fires++;
        if (first_fire < 0) begin
          first_fire = cyc + 1;
          first_addr = out_imem_req_addr;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each delivery and checks structural invariants.
  initial forever begin
    @(negedge in_clk);
    #4;
    if (in_rst) begin
      checks++;
      if (dut.outstanding > MAXO || dut.discard > dut.outstanding || dut.fifo_count > DEPTH ||
          (dut.fifo_push && dut.fifo_full && !dut.fifo_pop) || (dut.fifo_pop && dut.fifo_empty)) begin
        errors++;
        $display("FAIL invariant outstanding=%0d discard=%0d count=%0d push=%0b pop=%0b",
                 dut.outstanding, dut.discard, dut.fifo_count, dut.fifo_push, dut.fifo_pop);
      end
      if (out_d_done) begin
        if (first_done < 0) first_done = cyc + 1;
        delivered++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery actual pc=%h insn=%h required none", out_d_pc, out_d_insnbits);
        end else begin
          mon_e = exp_q.pop_front();
          chk("d_pc", out_d_pc, mon_e);
          chk("d_insn", 64'(out_d_insnbits), 64'(insn_at(mon_e)));
        end
      end
    end
  end

  initial begin : stim
    int n;
    int f0;
    int d0;
    int exp_disc;

    in_rst = 1'b0;
    repeat (3) step();
    chk("rst_req_valid", 64'(out_imem_req_valid), 0);
    chk("rst_req_addr", out_imem_req_addr, RST_PC);
    chk("rst_done", 64'(out_d_done), 0);
    chk("rst_insn", 64'(out_d_insnbits), 0);
    chk("rst_pc", out_d_pc, 0);
    chk("rst_halted", 64'(out_halted), 0);

    // Reset and first fetch, latency 1.
    lat = 1;
    load_stream(RST_PC, 400);
    in_rst = 1'b1;
    n = 0;
    while (first_done < 0 && n < 50) begin step(); n++; end
    chk("first_done_seen", 64'(first_done >= 0), 1);
    chk("first_req_addr", first_addr, RST_PC);
    chk("first_latency", 64'(first_done - first_fire), 2);
    repeat (20) step();

    // Reset mid-operation, then stall back-pressure.
    in_rst = 1'b0;
    in_stall = 1'b1;
    #1;
    chk("midrst_req_valid", 64'(out_imem_req_valid), 0);
    chk("midrst_addr", out_imem_req_addr, RST_PC);
    chk("midrst_count", 64'(dut.fifo_count), 0);
    step();
    load_stream(RST_PC, 400);
    f0 = fires;
    in_rst = 1'b1;
    repeat (10) step();
    chk("stall_fires", 64'(fires - f0), 4);
    chk("stall_credit", 64'(dut.outstanding) + 64'(dut.fifo_count), 4);
    chk("stall_req_valid", 64'(out_imem_req_valid), 0);
    d0 = delivered;
    in_stall = 1'b0;
    repeat (4) step();
    chk("release_run", 64'(delivered - d0), 4);
    repeat (10) step();

    // Redirect with requests in flight, latency 3.
    lat = 3;
    n = 0;
    while (dut.outstanding != 3 && n < 100) begin step(); n++; end
    chk("three_outstanding", 64'(dut.outstanding), 3);
    exp_disc = mq.size();
    in_rob_redirect = 1'b1;
    in_rob_redirect_pc = 64'h2000;
    load_stream(64'h2000, 400);
    #1;
    chk("redir_no_done", 64'(out_d_done), 0);
    chk("redir_no_req", 64'(out_imem_req_valid), 0);
    step();
    in_rob_redirect = 1'b0;
    chk("redir_discard", 64'(dut.discard), 64'(exp_disc));
    chk("redir_fifo_empty", 64'(dut.fifo_count), 0);
    chk("redir_empty_insn", 64'(out_d_insnbits), 0);
    chk("redir_addr", out_imem_req_addr, 64'h2000);
    repeat (30) step();

    // Redirect coinciding with a response and a pop; low PC bits ignored.
    lat = 1;
    repeat (10) step();
    n = 0;
    while (!(in_imem_resp_valid && out_d_done) && n < 50) begin step(); n++; end
    chk("coincide_found", 64'(in_imem_resp_valid && out_d_done), 1);
    exp_disc = mq.size();
    in_rob_redirect = 1'b1;
    in_rob_redirect_pc = 64'h2403;
    load_stream(64'h2400, 400);
    #1;
    chk("coincide_no_done", 64'(out_d_done), 0);
    step();
    in_rob_redirect = 1'b0;
    chk("coincide_discard", 64'(dut.discard), 64'(exp_disc));
    chk("coincide_addr", out_imem_req_addr, 64'h2400);
    repeat (20) step();

    // Halt: HLT at 0x100C is delivered, then fetch stops.
    hlt_addr = 64'h100C;
    in_rob_redirect = 1'b1;
    in_rob_redirect_pc = 64'h1000;
    load_stream(64'h1000, 4);
    step();
    in_rob_redirect = 1'b0;
    n = 0;
    while (!out_halted && n < 50) begin step(); n++; end
    chk("halted", 64'(out_halted), 1);
    f0 = fires;
    repeat (20) step();
    chk("halt_no_fires", 64'(fires - f0), 0);
    chk("halt_all_delivered", 64'(exp_q.size()), 0);
    chk("halt_req_valid", 64'(out_imem_req_valid), 0);

    // Resume from HALTED via redirect.
    hlt_addr = '1;
    in_rob_redirect = 1'b1;
    in_rob_redirect_pc = 64'h3000;
    load_stream(64'h3000, 400);
    step();
    in_rob_redirect = 1'b0;
    chk("resume_halted", 64'(out_halted), 0);
    chk("resume_addr", out_imem_req_addr, 64'h3000);
    d0 = delivered;
    repeat (20) step();
    chk("resume_progress", 64'((delivered - d0) >= 10), 1);

    // Wrap-around soak: random stalls and ready, 200 instructions.
    lat = 2;
    rand_ready = 1'b1;
    in_rob_redirect = 1'b1;
    in_rob_redirect_pc = 64'h4000;
    load_stream(64'h4000, 600);
    step();
    in_rob_redirect = 1'b0;
    d0 = delivered;
    n = 0;
    while ((delivered - d0) < 200 && n < 4000) begin
      in_stall = ($urandom_range(0, 2) == 0);
      step();
      n++;
    end
    chk("soak_count", 64'((delivered - d0) >= 200), 1);
    in_stall = 1'b1;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
